// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Valid/ready ALU with one registered result stage.
//               Single-cycle ops (add, sub, and, or, xor, shl, shr) have
//               latency 1 and full throughput. Opcode 000 is either a
//               constant-zero op (default build) or an unsigned iterative
//               shift-add multiply (build with ALU_PIPE_MUL_EN defined).
//
// Parameters  : WIDTH    - operand/result width in bits (4..32)
//               OP_WIDTH - opcode width (must be 3)
//
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               in_valid   - request valid
//               in_ready   - request can be accepted this cycle
//               alu_op     - opcode
//               op1, op2   - operands
//               out_valid  - result register holds an unconsumed result
//               out_ready  - consumer takes the result this cycle
//               out        - result
//               flags      - {negative, overflow, carry, zero}
//
// Config      : ALU_PIPE_MUL_EN - enables the iterative multiplier on
//               opcode 000 and the MUL state.
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH    = 8,
    parameter int OP_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] alu_op,
    input  logic [WIDTH-1:0]    op1,
    input  logic [WIDTH-1:0]    op2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out,
    output logic [3:0]          flags
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [OP_WIDTH-1:0] c_OP_ADD = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] c_OP_SUB = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] c_OP_AND = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] c_OP_OR  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] c_OP_XOR = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] c_OP_SHL = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] c_OP_SHR = OP_WIDTH'(7);
`ifdef ALU_PIPE_MUL_EN
    localparam logic [OP_WIDTH-1:0] c_OP_MUL = OP_WIDTH'(0);
`endif

    // WIDTH always fits in WIDTH bits for WIDTH >= 2
    localparam logic [WIDTH-1:0] c_SHIFT_LIMIT = WIDTH'(WIDTH);

    // ------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------
`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0
    } state_t;
`endif

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_flags;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic w_out_free;
    logic w_accept;
    logic w_consume;
    logic w_single_accept;

    // The output slot can take a new value if it is empty or being drained
    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = w_out_free && (r_state == IDLE) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_consume  = r_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_add_ext;
    logic [WIDTH:0]   w_sub_ext;
    logic             w_shift_oob;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic [3:0]       w_alu_flags;

    assign w_add_ext   = {1'b0, op1} + {1'b0, op2};
    // The extra top bit of the zero-extended difference is the borrow
    assign w_sub_ext   = {1'b0, op1} - {1'b0, op2};
    assign w_shift_oob = (op2 >= c_SHIFT_LIMIT);

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (alu_op)
            c_OP_ADD: begin
                w_alu_res = w_add_ext[WIDTH-1:0];
                w_alu_c   = w_add_ext[WIDTH];
                // Same-sign operands producing an opposite-sign sum
                w_alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                            (w_add_ext[WIDTH-1] != op1[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_alu_res = w_sub_ext[WIDTH-1:0];
                w_alu_c   = w_sub_ext[WIDTH];
                // Different-sign operands where the result sign flips from op1
                w_alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                            (w_sub_ext[WIDTH-1] != op1[WIDTH-1]);
            end
            c_OP_AND: w_alu_res = op1 & op2;
            c_OP_OR:  w_alu_res = op1 | op2;
            c_OP_XOR: w_alu_res = op1 ^ op2;
            c_OP_SHL: w_alu_res = w_shift_oob ? '0 : (op1 << op2);
            c_OP_SHR: w_alu_res = w_shift_oob ? '0 : (op1 >> op2);
            // Opcode 000 in the single-cycle path always yields zero
            default:  w_alu_res = '0;
        endcase
    end

    assign w_alu_flags = {w_alu_res[WIDTH-1], w_alu_v, w_alu_c, (w_alu_res == '0)};

`ifdef ALU_PIPE_MUL_EN
    // ------------------------------------------------------------------
    // Iterative shift-add multiplier
    // ------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_CNT_W-1:0] r_mul_cnt;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_mul_last;
    logic               w_mul_start;
    logic               w_mul_done;
    logic               w_mul_step;
    logic [3:0]         w_mul_flags;

    assign w_single_accept = w_accept && (alu_op != c_OP_MUL);
    assign w_prod_next     = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last      = (r_mul_cnt == c_CNT_W'(WIDTH - 1));
    // The final step waits if an earlier result is still occupying the
    // output register, so it can never be overwritten before consumption.
    assign w_mul_step      = (r_state == MUL) && !(w_mul_last && !w_out_free);
    assign w_mul_flags     = {w_prod_next[WIDTH-1], 1'b0,
                              (w_prod_next[2*WIDTH-1:WIDTH] != '0),
                              (w_prod_next[WIDTH-1:0] == '0)};

    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        w_mul_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (alu_op == c_OP_MUL)) begin
                    w_mul_start  = 1'b1;
                    w_state_next = MUL;
                end
            end
            MUL: begin
                if (w_mul_last && w_out_free) begin
                    w_mul_done   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_prod    <= '0;
            r_mplier  <= '0;
            r_mul_cnt <= '0;
        end else if (w_mul_start) begin
            r_mcand   <= {{WIDTH{1'b0}}, op1};
            r_prod    <= '0;
            r_mplier  <= op2;
            r_mul_cnt <= '0;
        end else if (w_mul_step) begin
            // One multiplier bit per cycle, LSB first
            r_prod    <= w_prod_next;
            r_mcand   <= r_mcand << 1;
            r_mplier  <= r_mplier >> 1;
            r_mul_cnt <= r_mul_cnt + c_CNT_W'(1);
        end
    end
`else
    assign w_single_accept = w_accept;

    always_comb begin
        w_state_next = IDLE;
    end
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Result register: a new result takes priority over a consume on
    // the same edge, keeping throughput at one per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_flags     <= '0;
        end else if (w_single_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_alu_res;
            r_flags     <= w_alu_flags;
`ifdef ALU_PIPE_MUL_EN
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_out       <= w_prod_next[WIDTH-1:0];
            r_flags     <= w_mul_flags;
`endif
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe (WIDTH=8). Expected results
//               are computed by an integer model, queued at accept time and
//               compared when the DUT hands a result over. Multiply tests are
//               built only when ALU_PIPE_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam logic [2:0] c_MUL = 3'd0;
    localparam logic [2:0] c_ADD = 3'd1;
    localparam logic [2:0] c_SUB = 3'd2;
    localparam logic [2:0] c_AND = 3'd3;
    localparam logic [2:0] c_OR  = 3'd4;
    localparam logic [2:0] c_XOR = 3'd5;
    localparam logic [2:0] c_SHL = 3'd6;
    localparam logic [2:0] c_SHR = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] alu_op;
    logic [7:0] op1;
    logic [7:0] op2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [3:0] flags;

    logic [11:0] sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .OP_WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    // Reference model: returns {flags, result} using integer arithmetic
    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int ua;
        int ub;
        int sa;
        int sb;
        int r;
        logic c;
        logic v;
        logic [7:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            c_ADD: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            c_SUB: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            c_AND: r = ua & ub;
            c_OR:  r = ua | ub;
            c_XOR: r = ua ^ ub;
            c_SHL: r = (ub >= 8) ? 0 : (ua << ub);
            c_SHR: r = (ub >= 8) ? 0 : (ua >> ub);
`ifdef ALU_PIPE_MUL_EN
            default: begin r = ua * ub; c = (r > 255); end
`else
            default: r = 0;
`endif
        endcase
        res = r[7:0];
        return {res[7], v, c, (res == 8'h00), res};
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic rdy);
        in_valid  = v;
        alu_op    = op;
        op1       = a;
        op2       = b;
        out_ready = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, c_ADD, 8'h00, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if ({flags, out} !== 12'h000) begin n_fail++; $display("FAIL reset_out_flags: got %h expected 000", {flags, out}); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    // One op at a time: latency 1, then a consumed result with no new accept
    task automatic test_ops();
        logic [2:0] t_op[13] = '{c_ADD, c_SUB, c_SHL, c_ADD, c_SUB, c_AND, c_OR,
                                 c_XOR, c_SHL, c_SHR, c_SHR, c_SUB, c_ADD};
        logic [7:0] t_a[13]  = '{8'h7F, 8'h00, 8'h81, 8'hFF, 8'h80, 8'hCA, 8'h50,
                                 8'hFF, 8'h01, 8'h80, 8'hFF, 8'h05, 8'h80};
        logic [7:0] t_b[13]  = '{8'h01, 8'h01, 8'h09, 8'h01, 8'h01, 8'h5F, 8'h0A,
                                 8'hFF, 8'h07, 8'h07, 8'h08, 8'h05, 8'h80};
        logic [11:0] exp_v;
        logic [11:0] last_v;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, t_op[i], t_a[i], t_b[i], 1'b1);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ops_in_ready[%0d]: got %b expected 1", i, in_ready); end
            if (in_valid && in_ready) sb_q.push_back(model(t_op[i], t_a[i], t_b[i]));
            @(posedge clk);
            #1;
            drive(1'b0, c_ADD, 8'h00, 8'h00, 1'b1);
            #1;
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ops_latency[%0d]: out_valid got %b expected 1", i, out_valid); end
            if (out_valid && out_ready) begin
                exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hXXX;
                last_v = exp_v;
                n_checks++;
                if ({flags, out} !== exp_v) begin
                    n_fail++;
                    $display("FAIL ops_result[%0d]: got flags=%b out=%h expected flags=%b out=%h",
                             i, flags, out, exp_v[11:8], exp_v[7:0]);
                end
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || {flags, out} !== last_v) begin
                n_fail++;
                $display("FAIL ops_drain[%0d]: got valid=%b %h expected valid=0 %h", i, out_valid, {flags, out}, last_v);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_v;
        drive(1'b1, c_ADD, 8'h12, 8'h34, 1'b1);
        #1;
        if (in_valid && in_ready) sb_q.push_back(model(c_ADD, 8'h12, 8'h34));
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, c_SUB, 8'h99, 8'h11, 1'b0);
            #1;
            exp_v = (sb_q.size() > 0) ? sb_q[0] : 12'hXXX;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {flags, out} !== exp_v) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got in_ready=%b valid=%b %h expected 0 1 %h",
                         k, in_ready, out_valid, {flags, out}, exp_v);
            end
            if (in_valid && in_ready) sb_q.push_back(model(c_SUB, 8'h99, 8'h11));
            @(posedge clk);
            #1;
        end
        drive(1'b1, c_OR, 8'hF0, 8'h0F, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        if (out_valid && out_ready) begin
            exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hXXX;
            n_checks++;
            if ({flags, out} !== exp_v) begin n_fail++; $display("FAIL bp_consume: got %h expected %h", {flags, out}, exp_v); end
        end
        if (in_valid && in_ready) sb_q.push_back(model(c_OR, 8'hF0, 8'h0F));
        @(posedge clk);
        #1;
        drive(1'b0, c_ADD, 8'h00, 8'h00, 1'b1);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b expected 1", out_valid); end
        if (out_valid && out_ready) begin
            exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hXXX;
            n_checks++;
            if ({flags, out} !== exp_v) begin n_fail++; $display("FAIL bp_next_result: got %h expected %h", {flags, out}, exp_v); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        logic [7:0] a;
        logic [7:0] b;
        logic [11:0] exp_v;
        for (int cyc = 0; cyc < 30 && got < 10; cyc++) begin
            a = 8'((sent * 37 + 5) & 255);
            b = 8'((sent * 11 + 3) & 255);
            if (sent < 10) drive(1'b1, c_XOR, a, b, 1'b1);
            else drive(1'b0, c_XOR, 8'h00, 8'h00, 1'b1);
            #1;
            if (out_valid && out_ready) begin
                exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hXXX;
                n_checks++;
                if ({flags, out} !== exp_v) begin
                    n_fail++;
                    $display("FAIL stream_result[%0d]: got %h expected %h", got, {flags, out}, exp_v);
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(c_XOR, a, b));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (got != 10 || (last_cyc - first_cyc) != 9) begin
            n_fail++;
            $display("FAIL stream_gapless: got %0d results over %0d cycles expected 10 over 10",
                     got, last_cyc - first_cyc + 1);
        end
        drive(1'b0, c_ADD, 8'h00, 8'h00, 1'b1);
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mul();
        logic [11:0] exp_v;
        int seen = 0;
        drive(1'b1, c_MUL, 8'h10, 8'h11, 1'b1);
        #1;
        if (in_valid && in_ready) sb_q.push_back(model(c_MUL, 8'h10, 8'h11));
        @(posedge clk);
        #1;
        for (int k = 1; k <= 9; k++) begin
            drive(1'b0, c_ADD, 8'h00, 8'h00, 1'b1);
            #1;
            n_checks++;
            if (out_valid !== (k == 9)) begin
                n_fail++;
                $display("FAIL mul_latency[%0d]: out_valid got %b expected %b", k, out_valid, (k == 9));
            end
            if (k < 9) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready[%0d]: got %b expected 0", k, in_ready); end
            end
            if (out_valid && out_ready) begin
                exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hXXX;
                seen++;
                n_checks++;
                if ({flags, out} !== exp_v) begin n_fail++; $display("FAIL mul_result: got %h expected %h", {flags, out}, exp_v); end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen != 1) begin n_fail++; $display("FAIL mul_count: got %0d results expected 1", seen); end
    endtask

    task automatic test_mul_reset();
        drive(1'b1, c_MUL, 8'h0F, 8'h0F, 1'b1);
        #1;
        if (in_valid && in_ready) sb_q.push_back(model(c_MUL, 8'h0F, 8'h0F));
        @(posedge clk);
        #1;
        drive(1'b0, c_ADD, 8'h00, 8'h00, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mulrst_in_ready_rst: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mulrst_in_ready: got %b expected 1", in_ready); end
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mulrst_no_result[%0d]: got %b expected 0", k, out_valid); end
            @(posedge clk);
            #1;
        end
    endtask
`else
    task automatic test_op0();
        logic [11:0] exp_v;
        drive(1'b1, c_MUL, 8'h5A, 8'h33, 1'b1);
        #1;
        if (in_valid && in_ready) sb_q.push_back(model(c_MUL, 8'h5A, 8'h33));
        @(posedge clk);
        #1;
        drive(1'b0, c_ADD, 8'h00, 8'h00, 1'b1);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL op0_latency: got %b expected 1", out_valid); end
        if (out_valid && out_ready) begin
            exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hXXX;
            n_checks++;
            if ({flags, out} !== exp_v) begin n_fail++; $display("FAIL op0_result: got %h expected %h", {flags, out}, exp_v); end
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(1'b0, c_ADD, 8'h00, 8'h00, 1'b0);
        test_reset();
        test_ops();
        test_backpressure();
        test_back_to_back();
`ifdef ALU_PIPE_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_op0();
`endif
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d pending expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
